// File: rtl/codec_rx_intf.sv
// codec_rx_intf
//   Master-mode serial audio receiver. Derives the codec bit clock (SCLK) and
//   word clock (LRCLK) from a free-running 10-bit frame counter, deserializes
//   SDout into 16-bit signed left/right samples and presents each pair with a
//   one-cycle vld strobe once per 1024-clk frame. The first DISCARD_FRAMES
//   complete frames after reset are dropped while the codec settles.
//
// Ports
//   clk         system clock
//   rst_n       synchronous, active-low reset
//   SDout       serial data from codec, MSB first, asynchronous to clk
//   SCLK        bit clock to codec, period 32 clk
//   LRCLK       word clock to codec, low = left half, high = right half
//   lft_chnnl   signed left sample, two's complement
//   rght_chnnl  signed right sample, two's complement
//   vld         one-cycle strobe, new lft_chnnl/rght_chnnl pair valid

module codec_rx_intf #(
    parameter int DISCARD_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SDout,
    output logic        SCLK,
    output logic        LRCLK,
    output logic [15:0] lft_chnnl,
    output logic [15:0] rght_chnnl,
    output logic        vld
);

    localparam logic [3:0] DISCARD_INIT = 4'(DISCARD_FRAMES);

    logic [9:0]  cnt;
    logic        sync1;
    logic        sync2;
    logic [15:0] lft_shft;
    logic [15:0] rght_shft;
    logic [3:0]  discard_cnt;
    logic        capture;
    logic        frame_end;

    // Sample two clk after the SCLK rising edge: SCLK is cnt[4] delayed one
    // clk, and the synchronizer adds another clk of latency on SDout.
    assign capture   = (cnt[4:0] == 5'b10001);
    assign frame_end = (cnt == 10'h3FF);

    // Timing base; SCLK/LRCLK are registered so they never glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= 10'd0;
            SCLK  <= 1'b0;
            LRCLK <= 1'b0;
        end else begin
            cnt   <= cnt + 10'd1;
            SCLK  <= cnt[4];
            LRCLK <= cnt[9];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= SDout;
            sync2 <= sync1;
        end
    end

    // Each half shifts exactly 16 bits, so at frame end the registers hold a
    // complete word without needing to be cleared between frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lft_shft  <= 16'h0000;
            rght_shft <= 16'h0000;
        end else if (capture) begin
            if (cnt[9]) begin
                rght_shft <= {rght_shft[14:0], sync2};
            end else begin
                lft_shft <= {lft_shft[14:0], sync2};
            end
        end
    end

    // Both channels load on the same edge so a pair is never split.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lft_chnnl   <= 16'h0000;
            rght_chnnl  <= 16'h0000;
            vld         <= 1'b0;
            discard_cnt <= DISCARD_INIT;
        end else begin
            vld <= 1'b0;
            if (frame_end) begin
                if (discard_cnt == 4'd0) begin
                    lft_chnnl  <= lft_shft;
                    rght_chnnl <= rght_shft;
                    vld        <= 1'b1;
                end else begin
                    discard_cnt <= discard_cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_codec_rx_intf.sv
module tb_codec_rx_intf;

    localparam int NF = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SDout = 1'b0;

    logic        sclk2, lrclk2, vld2;
    logic [15:0] lft2, rght2;
    logic        sclk0, lrclk0, vld0;
    logic [15:0] lft0, rght0;

    codec_rx_intf #(.DISCARD_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .SDout(SDout),
        .SCLK(sclk2), .LRCLK(lrclk2),
        .lft_chnnl(lft2), .rght_chnnl(rght2), .vld(vld2)
    );

    codec_rx_intf #(.DISCARD_FRAMES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .SDout(SDout),
        .SCLK(sclk0), .LRCLK(lrclk0),
        .lft_chnnl(lft0), .rght_chnnl(rght0), .vld(vld0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] l_in;
        logic [15:0] r_in;
        logic        exp_vld;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs [NF];

    int n_tests = 0;
    int n_fail  = 0;

    // Bench time base: cycles since reset release, independent of the DUT.
    int   tc = 0;
    logic rst_q = 1'b0;
    logic started = 1'b0;

    always @(posedge clk) begin
        tc      <= rst_n ? tc + 1 : 0;
        rst_q   <= rst_n;
        started <= 1'b1;
    end

    // Codec model: each 32-clk slot carries one bit, MSB first, left half
    // first. Data changes at the start of the slot.
    int          cf;
    logic [9:0]  cc;
    logic [15:0] cw;
    always @(posedge clk) begin
        #1;
        cf = tc / 1024;
        cc = 10'(tc % 1024);
        if (cf < NF) cw = cc[9] ? vecs[cf].r_in : vecs[cf].l_in;
        else         cw = 16'h0000;
        SDout = cw[4'd15 - cc[8:5]];
    end

    // Continuous monitors; their error tallies are compared at the end.
    int          clk_err = 0;
    int          hold_err = 0;
    int          vtime_err = 0;
    int          vcnt2 = 0;
    int          vcnt0 = 0;
    logic        pv2 = 1'b0, pv0 = 1'b0;
    logic [15:0] pl2 = '0, pr2 = '0, pl0 = '0, pr0 = '0;
    logic [9:0]  pc;
    logic        es, el;

    always @(negedge clk) begin
        if (started) begin
            if (!rst_q) begin
                es = 1'b0;
                el = 1'b0;
            end else begin
                pc = 10'((tc + 1023) % 1024);
                es = pc[4];
                el = pc[9];
            end
            if (sclk2 !== es || lrclk2 !== el || sclk0 !== es || lrclk0 !== el)
                clk_err++;
            if (rst_q) begin
                if (!vld2 && (lft2 !== pl2 || rght2 !== pr2)) hold_err++;
                if (!vld0 && (lft0 !== pl0 || rght0 !== pr0)) hold_err++;
            end
            if (vld2 === 1'b1) begin
                vcnt2++;
                if ((tc % 1024) != 0 || tc == 0 || pv2) vtime_err++;
            end
            if (vld0 === 1'b1) begin
                vcnt0++;
                if ((tc % 1024) != 0 || tc == 0 || pv0) vtime_err++;
            end
            pv2 = vld2; pv0 = vld0;
            pl2 = lft2; pr2 = rght2; pl0 = lft0; pr0 = rght0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_tc(input int target);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (tc != target && guard < 20000);
        if (tc != target) check("wait_tc_timeout", 32'(tc), 32'(target));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sclk"},  {31'd0, sclk2},  32'd0);
        check({tag, "_lrclk"}, {31'd0, lrclk2}, 32'd0);
        check({tag, "_vld"},   {31'd0, vld2},   32'd0);
        check({tag, "_lft"},   {16'd0, lft2},   32'd0);
        check({tag, "_rght"},  {16'd0, rght2},  32'd0);
        check({tag, "_lft0"},  {16'd0, lft0},   32'd0);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'hEDCC, 1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{16'h1234, 16'hEDCC, 1'b0, 16'h0000, 16'h0000};
        vecs[2] = '{16'h1234, 16'hEDCC, 1'b1, 16'h1234, 16'hEDCC};
        vecs[3] = '{16'h8000, 16'h7FFF, 1'b1, 16'h8000, 16'h7FFF};
        vecs[4] = '{16'h7FFF, 16'h8000, 1'b1, 16'h7FFF, 16'h8000};
        vecs[5] = '{16'h0001, 16'h0002, 1'b1, 16'h0001, 16'h0002};
        vecs[6] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 16'h0000};
        vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'hA5A5, 16'h5A5A};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");

        @(posedge clk);
        #1 rst_n = 1'b1;

        // Frame i ends at cycle 1024*(i+1); dut shows frame i only once the
        // two discard frames are spent, dut0 shows every frame.
        for (int i = 0; i < NF; i++) begin
            wait_tc(1024 * (i + 1));
            check($sformatf("f%0d_vld2", i),  {31'd0, vld2},  {31'd0, vecs[i].exp_vld});
            if (vecs[i].exp_vld) begin
                check($sformatf("f%0d_lft2", i),  {16'd0, lft2},  {16'd0, vecs[i].exp_l});
                check($sformatf("f%0d_rght2", i), {16'd0, rght2}, {16'd0, vecs[i].exp_r});
            end else begin
                check($sformatf("f%0d_lft2_zero", i), {16'd0, lft2}, 32'd0);
            end
            check($sformatf("f%0d_vld0", i),  {31'd0, vld0},  32'd1);
            check($sformatf("f%0d_lft0", i),  {16'd0, lft0},  {16'd0, vecs[i].l_in});
            check($sformatf("f%0d_rght0", i), {16'd0, rght0}, {16'd0, vecs[i].r_in});
        end

        wait_tc(NF * 1024 + 1);
        check("cnt_vld2", 32'(vcnt2), 32'd6);
        check("cnt_vld0", 32'(vcnt0), 32'd8);
        check("vld2_off", {31'd0, vld2}, 32'd0);

        // Mid-frame reset: one-cycle low pulse during cnt == 0x1A3.
        wait_tc(NF * 1024 + 'h1A3);
        check("pre_rst_lft2", {16'd0, lft2}, 32'h0000A5A5);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_tc", 32'(tc), 32'd0);
        check_reset("mid");
        vcnt2 = 0;
        vcnt0 = 0;

        wait_tc(1024);
        check("mid_vld0", {31'd0, vld0}, 32'd1);
        check("mid_lft0", {16'd0, lft0}, 32'h00001234);
        check("mid_rght0", {16'd0, rght0}, 32'h0000EDCC);
        check("mid_vld2_disc", {31'd0, vld2}, 32'd0);

        wait_tc(3071);
        check("mid_no_vld2", 32'(vcnt2), 32'd0);
        check("mid_lft2_hold0", {16'd0, lft2}, 32'd0);
        wait_tc(3072);
        check("mid_vld2", {31'd0, vld2}, 32'd1);
        check("mid_lft2", {16'd0, lft2}, 32'h00001234);
        check("mid_rght2", {16'd0, rght2}, 32'h0000EDCC);
        wait_tc(3073);
        check("mid_cnt_vld2", 32'(vcnt2), 32'd1);
        check("mid_cnt_vld0", 32'(vcnt0), 32'd3);

        check("sclk_lrclk_err", 32'(clk_err), 32'd0);
        check("hold_err", 32'(hold_err), 32'd0);
        check("vld_timing_err", 32'(vtime_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/codec_rx_intf.md
Name: codec_rx_intf

Overview:
- Master-mode serial audio receiver that sits directly upstream of the LED intensity driver and any other sample consumers.
- Generates the codec bit clock (SCLK) and word clock (LRCLK) from clk, and deserializes the codec's SDout line into 16-bit signed left/right samples.
- Presents each left/right pair together with a one-cycle vld strobe, once per frame.
- Discards a configurable number of frames after reset while the codec settles.

Parameters:
- DISCARD_FRAMES, 2, number of complete frames after reset for which no vld is issued (range 0-15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous, active-low reset
- SDout  input  1  serial data from codec, MSB first, asynchronous to clk
- SCLK  output  1  bit clock to codec, period 32 clk
- LRCLK  output  1  word clock to codec; low = left half, high = right half; period 1024 clk
- lft_chnnl  output  16  signed left sample, two's complement
- rght_chnnl  output  16  signed right sample, two's complement
- vld  output  1  one-cycle strobe: new lft_chnnl/rght_chnnl pair valid

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low: all state updates only on posedge clk while rst_n is low.

Reset state:
- cnt = 0
- SCLK = 0, LRCLK = 0, vld = 0
- lft_chnnl = 0, rght_chnnl = 0
- shift registers = 0, sync flops = 0
- discard counter = DISCARD_FRAMES

Timing base:
- 10-bit free-running frame counter cnt, increments every clk and wraps 10'h3FF -> 10'h000.
- SCLK = registered cnt[4]. LRCLK = registered cnt[9]. Both are glitch-free.
- Each LRCLK half holds 16 SCLK periods, giving 16 bit slots. Bit slot index = cnt[8:5]; slot 0 carries the MSB.

Input sampling:
- SDout passes through a 2-flop synchronizer before use.
- The synchronized bit is captured when cnt[4:0] == 5'b10001, i.e. 2 clk after the SCLK rising edge, which compensates for the synchronizer delay.

Deserialization:
- cnt[9] == 0: the captured bit shifts into the left shift register (shift left, LSB in).
- cnt[9] == 1: the captured bit shifts into the right shift register.
- The last right-channel bit is captured at cnt == 10'h3F1.

Frame end (clock edge where cnt goes 10'h3FF -> 10'h000):
- Discard counter == 0:
  - lft_chnnl <= left shift register, rght_chnnl <= right shift register.
  - vld <= 1, so vld is high for exactly the one cycle in which cnt == 0.
- Discard counter != 0:
  - Decrement the discard counter.
  - Outputs unchanged, vld stays 0.

Other rules:
- vld is 0 in every cycle where cnt != 0. The vld period is exactly 1024 clk.
- lft_chnnl and rght_chnnl hold their value between vld pulses. Downstream may sample them at any time, but must treat vld as the update event.
- Both channels always update together on the same edge; a pair is never split across two vld pulses.
- Reset mid-frame: partial shift contents are lost, cnt restarts at 0, and the discard counter reloads. The first vld after reset release occurs DISCARD_FRAMES+1 frames later.
- DISCARD_FRAMES = 0: vld is issued at the first frame end, 1024 cycles after reset release.
- No backpressure: the consumer must accept every vld.

Test Plan:
1. Reset release, SDout = 0 -> SCLK toggles every 16 clk. LRCLK toggles every 512 clk. lft_chnnl = rght_chnnl = 0, vld = 0 throughout the first 2 frames.
2. DISCARD_FRAMES = 2, codec model drives left 16'h1234 and right 16'hEDCC every frame -> the first vld occurs in the cycle where cnt == 0 after the third frame end (cycle 3072 after reset release). lft_chnnl = 16'h1234 and rght_chnnl = 16'hEDCC on that cycle, then vld repeats every 1024 clk.
3. Extremes: left 16'h8000, right 16'h7FFF -> lft_chnnl = 16'h8000 (-32768) and rght_chnnl = 16'h7FFF, no bit slip. Swapping the values gives swapped outputs on the next vld.
4. Data change: frame N = (16'h0001, 16'h0002), frame N+1 = (16'hFFFF, 16'h0000) -> outputs hold (1, 2) for all 1023 cycles between pulses, then switch atomically to (16'hFFFF, 16'h0000) on the next vld.
5. rst_n pulsed low for 1 cycle at cnt == 10'h1A3 -> all outputs return to their reset values, SCLK and LRCLK restart from 0, and no vld occurs for the next 2 frames.
6. DISCARD_FRAMES = 0, left 16'hA5A5, right 16'h5A5A -> vld in cycle 1024 after reset release with exactly these values. vld is never high for 2 consecutive cycles.
